// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encoding and requester indices.
package interrupt_arbiter_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_ISSUE = 4'b0010,
      ST_ACK   = 4'b0100,
      ST_GAP   = 4'b1000
   } state_t;

   localparam logic RX = 1'b0;
   localparam logic TX = 1'b1;

   localparam int GAP_CNT_W = 16;

   // Number of active requesters in a two-bit request vector, widened for counter arithmetic.
   function automatic logic [31:0] req_count(input logic [1:0] req);
      return {31'd0, req[0]} + {31'd0, req[1]};
   endfunction

endpackage

// File: rtl/interrupt_arbiter_rr_pick2.sv
// Combinational round-robin picker for two requesters; on a tie the one not granted last wins.
module rr_pick2
   import interrupt_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      grant = RX;
      if (req == 2'b11) begin
         grant = ~last;
      end else if (req[TX]) begin
         grant = TX;
      end
   end

endmodule

// File: rtl/interrupt_arbiter.sv
// Shares the core interrupt handshake between rx and tx generators with round-robin grant,
// a post-handshake gap, and drop-when-disabled. Optional macro INTR_COALESCE_EN acks both.
module interrupt_arbiter
   import interrupt_arbiter_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        cfg_interrupt_n,
   input  logic        cfg_interrupt_rdy_n,
   input  logic        rx_interrupt_n,
   output logic        rx_interrupt_rdy_n,
   input  logic        tx_interrupt_n,
   output logic        tx_interrupt_rdy_n,
   input  logic        interrupts_enabled,
   output logic [31:0] intr_issued,
   output logic [31:0] intr_dropped
);

   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

   state_t               state_reg;
   logic                 cfg_n_reg;
   logic [1:0]           rdy_n_reg;
   logic                 grant_reg;
   logic                 last_grant_reg;
   logic [GAP_CNT_W-1:0] gap_cnt_reg;
   logic [31:0]          issued_reg;
   logic [31:0]          dropped_reg;

   logic [1:0] req_n;
   logic [1:0] req;
   logic       pick_grant;
   logic       pick_valid;
   logic [1:0] ack_mask_next;

   assign req_n = {tx_interrupt_n, rx_interrupt_n};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign req[gi] = ~req_n[gi];
      end
   endgenerate

   rr_pick2 u_pick (
      .req   (req),
      .last  (last_grant_reg),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // Requesters acknowledged on the core handshake edge.
   always_comb begin
      ack_mask_next = 2'b00;
      ack_mask_next[grant_reg] = 1'b1;
`ifdef INTR_COALESCE_EN
      ack_mask_next = ack_mask_next | req;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         cfg_n_reg      <= 1'b1;
         rdy_n_reg      <= 2'b11;
         grant_reg      <= RX;
         last_grant_reg <= TX;
         gap_cnt_reg    <= '0;
         issued_reg     <= '0;
         dropped_reg    <= '0;
      end else begin
         // Acknowledges are single-cycle pulses; only the branches below assert them.
         rdy_n_reg <= 2'b11;
         unique case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  if (!interrupts_enabled) begin
                     rdy_n_reg   <= ~req;
                     dropped_reg <= dropped_reg + req_count(req);
                     gap_cnt_reg <= '0;
                     state_reg   <= ST_GAP;
                  end else begin
                     cfg_n_reg      <= 1'b0;
                     grant_reg      <= pick_grant;
                     last_grant_reg <= pick_grant;
                     state_reg      <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (!cfg_interrupt_rdy_n) begin
                  cfg_n_reg  <= 1'b1;
                  rdy_n_reg  <= ~ack_mask_next;
                  issued_reg <= issued_reg + 32'd1;
                  state_reg  <= ST_ACK;
               end
            end
            ST_ACK: begin
               gap_cnt_reg <= '0;
               state_reg   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  gap_cnt_reg <= '0;
                  state_reg   <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            default: begin
               cfg_n_reg <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_interrupt_n    = cfg_n_reg;
   assign rx_interrupt_rdy_n = rdy_n_reg[RX];
   assign tx_interrupt_rdy_n = rdy_n_reg[TX];
   assign intr_issued        = issued_reg;
   assign intr_dropped       = dropped_reg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_interrupt_arbiter;

   localparam int unsigned GAP = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_interrupt_n;
   logic        cfg_interrupt_rdy_n = 1'b1;
   logic        rx_interrupt_n = 1'b1;
   logic        rx_interrupt_rdy_n;
   logic        tx_interrupt_n = 1'b1;
   logic        tx_interrupt_rdy_n;
   logic        interrupts_enabled = 1'b1;
   logic [31:0] intr_issued;
   logic [31:0] intr_dropped;

   int vec_cnt = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   interrupt_arbiter #(.GAP_CYCLES(GAP)) dut (
      .clk                 (clk),
      .reset               (reset),
      .cfg_interrupt_n     (cfg_interrupt_n),
      .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
      .rx_interrupt_n      (rx_interrupt_n),
      .rx_interrupt_rdy_n  (rx_interrupt_rdy_n),
      .tx_interrupt_n      (tx_interrupt_n),
      .tx_interrupt_rdy_n  (tx_interrupt_rdy_n),
      .interrupts_enabled  (interrupts_enabled),
      .intr_issued         (intr_issued),
      .intr_dropped        (intr_dropped)
   );

   typedef struct {
      logic       rx_n;
      logic       tx_n;
      logic       en;
      logic       ack_n;
      logic [2:0] exp;   // {cfg_interrupt_n, rx_interrupt_rdy_n, tx_interrupt_rdy_n}
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_cfg_low();
      for (int i = 0; i < 40; i++) begin
         if (!cfg_interrupt_n) return;
         step();
      end
      check("cfg_assert_timeout", {31'd0, cfg_interrupt_n}, 32'd0);
   endtask

   // Waits for the grant, acks two cycles later, returns {tx_rdy_n, rx_rdy_n} seen after the ack edge.
   task automatic handshake(output logic [1:0] rdy);
      wait_cfg_low();
      step();
      step();
      cfg_interrupt_rdy_n = 1'b0;
      step();
      rdy = {tx_interrupt_rdy_n, rx_interrupt_rdy_n};
      cfg_interrupt_rdy_n = 1'b1;
      check("cfg_release_on_ack", {31'd0, cfg_interrupt_n}, 32'd1);
      step();
   endtask

   task automatic settle();
      rx_interrupt_n = 1'b1;
      tx_interrupt_n = 1'b1;
      repeat (GAP + 4) step();
   endtask

   initial begin
      logic [1:0]  rdy;
      logic [31:0] base;
      logic        cfg_seen_low;

      vecs[0]  = '{1, 1, 1, 1, 3'b111};
      vecs[1]  = '{0, 1, 1, 1, 3'b011};
      vecs[2]  = '{0, 1, 1, 1, 3'b011};
      vecs[3]  = '{0, 1, 1, 1, 3'b011};
      vecs[4]  = '{0, 1, 1, 0, 3'b101};
      vecs[5]  = '{1, 1, 1, 1, 3'b111};
      vecs[6]  = '{0, 1, 1, 1, 3'b111};
      vecs[7]  = '{0, 1, 1, 1, 3'b111};
      vecs[8]  = '{0, 1, 1, 1, 3'b111};
      vecs[9]  = '{0, 1, 1, 1, 3'b111};
      vecs[10] = '{0, 1, 1, 1, 3'b011};
      vecs[11] = '{0, 1, 1, 0, 3'b101};
      vecs[12] = '{1, 1, 1, 1, 3'b111};
      vecs[13] = '{1, 0, 1, 1, 3'b111};
      vecs[14] = '{1, 0, 1, 1, 3'b111};
      vecs[15] = '{1, 0, 1, 1, 3'b111};
      vecs[16] = '{1, 0, 1, 1, 3'b111};
      vecs[17] = '{1, 0, 1, 1, 3'b011};
      vecs[18] = '{1, 0, 1, 0, 3'b110};
      vecs[19] = '{1, 1, 1, 1, 3'b111};

      repeat (2) step();
      check("reset_outputs", {29'd0, cfg_interrupt_n, rx_interrupt_rdy_n, tx_interrupt_rdy_n}, 32'd7);
      check("reset_issued", intr_issued, 32'd0);
      check("reset_dropped", intr_dropped, 32'd0);
      reset = 1'b0;

      // Single rx handshake timing, gap enforcement, then a lone tx request.
      for (int i = 0; i < 20; i++) begin
         rx_interrupt_n      = vecs[i].rx_n;
         tx_interrupt_n      = vecs[i].tx_n;
         interrupts_enabled  = vecs[i].en;
         cfg_interrupt_rdy_n = vecs[i].ack_n;
         step();
         check($sformatf("vec%0d", i),
               {29'd0, cfg_interrupt_n, rx_interrupt_rdy_n, tx_interrupt_rdy_n}, {29'd0, vecs[i].exp});
      end
      check("table_issued", intr_issued, 32'd3);
      settle();

      // Both requesting continuously: alternate grants starting with rx.
      base = intr_issued;
      rx_interrupt_n = 1'b0;
      tx_interrupt_n = 1'b0;
`ifdef INTR_COALESCE_EN
      handshake(rdy);
      check("coalesce_rdy", {30'd0, rdy}, 32'd0);
      settle();
      check("coalesce_issued", intr_issued - base, 32'd1);
`else
      for (int g = 0; g < 4; g++) begin
         handshake(rdy);
         check($sformatf("rr_grant%0d", g), {30'd0, rdy}, (g % 2 == 0) ? 32'd2 : 32'd1);
      end
      settle();
      check("rr_issued", intr_issued - base, 32'd4);
`endif

      // Disabled: both requests dropped in the same cycle, no core interrupt.
      interrupts_enabled = 1'b0;
      rx_interrupt_n = 1'b0;
      tx_interrupt_n = 1'b0;
      step();
      check("drop_pulse", {29'd0, cfg_interrupt_n, rx_interrupt_rdy_n, tx_interrupt_rdy_n}, 32'd4);
      rx_interrupt_n = 1'b1;
      tx_interrupt_n = 1'b1;
      cfg_seen_low = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (!cfg_interrupt_n) cfg_seen_low = 1'b1;
      end
      check("drop_no_cfg", {31'd0, cfg_seen_low}, 32'd0);
      check("drop_count", intr_dropped, 32'd2);
      interrupts_enabled = 1'b1;

      // Enable falls while in ISSUE: handshake still completes.
      base = intr_issued;
      rx_interrupt_n = 1'b0;
      wait_cfg_low();
      interrupts_enabled = 1'b0;
      repeat (5) step();
      check("disable_issue_hold", {31'd0, cfg_interrupt_n}, 32'd0);
      cfg_interrupt_rdy_n = 1'b0;
      step();
      check("disable_issue_ack", {30'd0, cfg_interrupt_n, rx_interrupt_rdy_n}, 32'd2);
      cfg_interrupt_rdy_n = 1'b1;
      interrupts_enabled = 1'b1;
      settle();
      check("disable_issue_count", intr_issued - base, 32'd1);

      // Asynchronous reset two cycles into ISSUE, rx regranted afterwards.
      rx_interrupt_n = 1'b0;
      wait_cfg_low();
      step();
      step();
      #2 reset = 1'b1;
      #1 check("reset_async_cfg", {31'd0, cfg_interrupt_n}, 32'd1);
      check("reset_async_issued", intr_issued, 32'd0);
      step();
      reset = 1'b0;
      step();
      if (cfg_interrupt_n) step();
      check("reset_regrant", {31'd0, cfg_interrupt_n}, 32'd0);
      cfg_interrupt_rdy_n = 1'b0;
      step();
      cfg_interrupt_rdy_n = 1'b1;
      settle();

      // Counter wraps from all-ones to zero.
      force dut.issued_reg = 32'hFFFF_FFFF;
      step();
      release dut.issued_reg;
      step();
      check("wrap_preload", intr_issued, 32'hFFFF_FFFF);
      rx_interrupt_n = 1'b0;
      handshake(rdy);
      rx_interrupt_n = 1'b1;
      check("wrap_rdy", {30'd0, rdy}, 32'd2);
      check("wrap_issued", intr_issued, 32'd0);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
